// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: holds a word on D, walks addr through all
// eight selects and rebuilds the sampled F bits into rx_data.
module mux8_scan_ctrl #(
   parameter int unsigned BIT_CYCLES = 4,
   parameter bit          MSB_FIRST  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_data,
   output logic [7:0] D,
   output logic [2:0] addr,
   input  logic       F,
   output logic       bit_strobe,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [2:0] ADDR_START = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [7:0] CNT_LAST   = 8'(BIT_CYCLES - 1);

   state_t     state_q;
   logic [7:0] cnt_q;
   logic [2:0] step_q;
   logic [2:0] addr_q, addr_d;
   logic [7:0] data_q;
   logic [7:0] rx_q;
   logic       ready_q, busy_q, done_q;
   logic       strobe;

   // Sample point is the last clock of each step, so F has had the rest of
   // the step to settle after the addr change.
   assign strobe = (state_q == SCAN) && (cnt_q == CNT_LAST);
   assign addr_d = MSB_FIRST ? (addr_q - 3'd1) : (addr_q + 3'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         step_q  <= 3'd0;
         addr_q  <= ADDR_START;
         data_q  <= 8'd0;
         rx_q    <= 8'd0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_valid) begin
                  data_q  <= load_data;
                  addr_q  <= ADDR_START;
                  cnt_q   <= 8'd0;
                  step_q  <= 3'd0;
                  rx_q    <= 8'd0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (strobe) begin
                  rx_q[addr_q] <= F;
                  cnt_q        <= 8'd0;
                  step_q       <= step_q + 3'd1;
                  // Last bit: park addr at the start value instead of wrapping.
                  if (step_q == 3'd7) begin
                     addr_q  <= ADDR_START;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     addr_q <= addr_d;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign load_ready = ready_q;
   assign D          = data_q;
   assign addr       = addr_q;
   assign bit_strobe = strobe;
   assign busy       = busy_q;
   assign done       = done_q;
   assign rx_data    = rx_q;

endmodule
